// File: rtl/regfile_ctx_engine.sv
// Context save/restore engine for the 32x32 register file: streams registers out
// through read port A1 (save) or refills them through write port A3 (restore).
module regfile_ctx_engine #(
   parameter int SKIP_X0 = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        save_req,
   input  logic        restore_req,
   input  logic        abort,
   output logic        busy,
   output logic        done,
   output logic [4:0]  rf_a1,
   input  logic [31:0] rf_rd1,
   output logic        rf_we,
   output logic [4:0]  rf_a3,
   output logic [31:0] rf_wd,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_idx,
   output logic        out_last,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SAVE    = 2'd1,
      ST_RESTORE = 2'd2
   } state_t;

   localparam logic [5:0] FIRST = (SKIP_X0 != 0) ? 6'd1 : 6'd0;

   state_t      state_q, state_d;
   logic [5:0]  idx_q, idx_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_data_q, out_data_d;
   logic [4:0]  out_idx_q, out_idx_d;
   logic        out_last_q, out_last_d;
   logic        done_q, done_d;
   logic        load_s, hs_s, beat_s;

   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign in_ready  = (state_q == ST_RESTORE);
   assign rf_we     = in_valid && in_ready;
   assign rf_a1     = (state_q == ST_SAVE) ? idx_q[4:0] : 5'd0;
   assign rf_a3     = (state_q == ST_RESTORE) ? idx_q[4:0] : 5'd0;
   assign rf_wd     = (state_q == ST_RESTORE) ? in_data : 32'd0;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;

   // Next-state, index and output-register computation; abort overrides everything
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      load_s      = (state_q == ST_SAVE) && (!out_valid_q || out_ready) && (idx_q <= 6'd31);
      hs_s        = out_valid_q && out_ready;
      beat_s      = in_valid && (state_q == ST_RESTORE);
      if (abort) begin
         state_d     = ST_IDLE;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (save_req) begin
                  state_d = ST_SAVE;
                  idx_d   = FIRST;
               end else if (restore_req) begin
                  state_d = ST_RESTORE;
                  idx_d   = FIRST;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SAVE: begin
               // The output slot refills in the same cycle it drains, giving one word per cycle
               if (load_s) begin
                  out_data_d  = rf_rd1;
                  out_idx_d   = idx_q[4:0];
                  out_last_d  = (idx_q == 6'd31);
                  out_valid_d = 1'b1;
                  idx_d       = idx_q + 6'd1;
               end else if (hs_s) begin
                  out_valid_d = 1'b0;
               end else begin
                  out_valid_d = out_valid_q;
               end
               if (hs_s && out_last_q) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_SAVE;
               end
            end
            ST_RESTORE: begin
               if (beat_s) begin
                  idx_d = idx_q + 6'd1;
                  if (idx_q == 6'd31) begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ST_RESTORE;
                  end
               end else begin
                  state_d = ST_RESTORE;
               end
            end
            default: begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= 6'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= 32'd0;
         out_idx_q   <= 5'd0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_regfile_ctx_engine.sv
// Directed bench for regfile_ctx_engine: one instance with SKIP_X0=1, one with SKIP_X0=0,
// each attached to a behavioural 32x32 register file.
module tb_regfile_ctx_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // instance 0 (SKIP_X0 = 1)
   logic        reset, save_req, restore_req, abort, out_ready, in_valid;
   logic [31:0] in_data, rf_rd1, rf_wd, out_data;
   logic        busy, done, rf_we, out_valid, out_last, in_ready;
   logic [4:0]  rf_a1, rf_a3, out_idx;
   // instance 1 (SKIP_X0 = 0)
   logic        reset1, save_req1, restore_req1, abort1, out_ready1, in_valid1;
   logic [31:0] in_data1, rf_rd1_1, rf_wd1, out_data1;
   logic        busy1, done1, rf_we1, out_valid1, out_last1, in_ready1;
   logic [4:0]  rf_a1_1, rf_a3_1, out_idx1;

   regfile_ctx_engine #(.SKIP_X0(1)) u_dut0 (
      .clk(clk), .reset(reset), .save_req(save_req), .restore_req(restore_req), .abort(abort),
      .busy(busy), .done(done), .rf_a1(rf_a1), .rf_rd1(rf_rd1), .rf_we(rf_we), .rf_a3(rf_a3),
      .rf_wd(rf_wd), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data));

   regfile_ctx_engine #(.SKIP_X0(0)) u_dut1 (
      .clk(clk), .reset(reset1), .save_req(save_req1), .restore_req(restore_req1), .abort(abort1),
      .busy(busy1), .done(done1), .rf_a1(rf_a1_1), .rf_rd1(rf_rd1_1), .rf_we(rf_we1), .rf_a3(rf_a3_1),
      .rf_wd(rf_wd1), .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .out_idx(out_idx1), .out_last(out_last1), .in_valid(in_valid1), .in_ready(in_ready1),
      .in_data(in_data1));

   // register file models: x0 reads zero and ignores writes
   logic [31:0] rf0 [32];
   logic [31:0] rf1 [32];
   logic        pre_en;
   logic [31:0] pre_base;
   int          x0_wr0, x0_wr1;

   assign rf_rd1   = (rf_a1 == 5'd0) ? 32'd0 : rf0[rf_a1];
   assign rf_rd1_1 = (rf_a1_1 == 5'd0) ? 32'd0 : rf1[rf_a1_1];

   always @(posedge clk) begin
      if (pre_en) begin
         for (int i = 0; i < 32; i++) rf0[i] <= pre_base + 32'(i);
      end else if (rf_we && rf_a3 != 5'd0) begin
         rf0[rf_a3] <= rf_wd;
      end
      if (rf_we && rf_a3 == 5'd0) x0_wr0 <= x0_wr0 + 1;
      if (rf_we1 && rf_a3_1 != 5'd0) rf1[rf_a3_1] <= rf_wd1;
      if (rf_we1 && rf_a3_1 == 5'd0) x0_wr1 <= x0_wr1 + 1;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        sv, rs, ab, ordy, ivld;
      logic [31:0] idat;
      logic        busy, done, ovld, irdy, we;
      logic [4:0]  a1, a3;
   } vec_t;

   vec_t tv [12];

   int          nxt, dn, beats, n;
   logic        prev_stall, r, iv, ir, fin;
   logic [31:0] prev_data;
   logic [4:0]  prev_idx;

   initial begin
      // inputs: sv rs ab ordy ivld idat | expected: busy done ovld irdy we a1 a3
      tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};
      tv[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};
      tv[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd1};
      tv[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd2};
      tv[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2222, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 5'd2};
      tv[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};
      tv[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};
      tv[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd0};
      tv[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 5'd0};
      tv[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 5'd0};
      tv[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 5'd0};
      tv[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0};

      reset = 1'b1; save_req = 1'b0; restore_req = 1'b0; abort = 1'b0;
      out_ready = 1'b0; in_valid = 1'b0; in_data = 32'd0;
      reset1 = 1'b1; save_req1 = 1'b0; restore_req1 = 1'b0; abort1 = 1'b0;
      out_ready1 = 1'b0; in_valid1 = 1'b0; in_data1 = 32'd0;
      pre_en = 1'b0; pre_base = 32'd0; x0_wr0 = 0; x0_wr1 = 0;
      for (int i = 0; i < 32; i++) begin rf0[i] = 32'd0; rf1[i] = 32'd0; end

      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_last", {31'd0, out_last}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_idx", {27'd0, out_idx}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_rf_a1", {27'd0, rf_a1}, 32'd0);
      chk("rst_rf_a3", {27'd0, rf_a3}, 32'd0);
      reset = 1'b0; reset1 = 1'b0;

      // table: restore start/bubble/abort, then simultaneous requests, stalled save, abort
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         save_req = tv[i].sv; restore_req = tv[i].rs; abort = tv[i].ab;
         out_ready = tv[i].ordy; in_valid = tv[i].ivld; in_data = tv[i].idat;
         #2;
         chk("tv_busy", {31'd0, busy}, {31'd0, tv[i].busy});
         chk("tv_done", {31'd0, done}, {31'd0, tv[i].done});
         chk("tv_out_valid", {31'd0, out_valid}, {31'd0, tv[i].ovld});
         chk("tv_in_ready", {31'd0, in_ready}, {31'd0, tv[i].irdy});
         chk("tv_rf_we", {31'd0, rf_we}, {31'd0, tv[i].we});
         chk("tv_rf_a1", {27'd0, rf_a1}, {27'd0, tv[i].a1});
         chk("tv_rf_a3", {27'd0, rf_a3}, {27'd0, tv[i].a3});
         if (tv[i].ovld) chk("tv_out_idx", {27'd0, out_idx}, 32'd1);
      end
      @(negedge clk);
      chk("tv_rf_x1", rf0[1], 32'h1111);
      chk("tv_rf_x2", rf0[2], 32'h2222);

      // save with no backpressure
      pre_en = 1'b1; pre_base = 32'hA5A50000;
      @(negedge clk);
      pre_en = 1'b0;
      @(negedge clk);
      save_req = 1'b1; out_ready = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         save_req = 1'b0;
         chk("A_busy", {31'd0, busy}, {31'd0, (c >= 1 && c <= 32)});
         chk("A_done", {31'd0, done}, {31'd0, (c == 33)});
         chk("A_out_valid", {31'd0, out_valid}, {31'd0, (c >= 2 && c <= 32)});
         if (c >= 2 && c <= 32) begin
            chk("A_out_idx", {27'd0, out_idx}, 32'(c - 1));
            chk("A_out_data", out_data, 32'hA5A50000 + 32'(c - 1));
            chk("A_out_last", {31'd0, out_last}, {31'd0, (c == 32)});
         end
      end

      // save with pseudo-random backpressure
      @(negedge clk);
      save_req = 1'b1; out_ready = 1'b0;
      nxt = 1; dn = 0; prev_stall = 1'b0; fin = 1'b0;
      prev_data = 32'd0; prev_idx = 5'd0;
      for (int c = 0; c < 400 && !fin; c++) begin
         @(negedge clk);
         save_req = 1'b0;
         chk("B_done_busy_excl", {31'd0, done && busy}, 32'd0);
         if (done) begin dn++; fin = 1'b1; end
         if (prev_stall) begin
            chk("B_stall_valid", {31'd0, out_valid}, 32'd1);
            chk("B_stall_data", out_data, prev_data);
            chk("B_stall_idx", {27'd0, out_idx}, {27'd0, prev_idx});
         end
         r = 1'($urandom_range(0, 1));
         out_ready = r;
         if (out_valid && r) begin
            chk("B_beat_idx", {27'd0, out_idx}, 32'(nxt));
            chk("B_beat_data", out_data, 32'hA5A50000 + 32'(nxt));
            chk("B_beat_last", {31'd0, out_last}, {31'd0, (nxt == 31)});
            nxt++;
         end
         prev_stall = out_valid && !r;
         prev_data = out_data; prev_idx = out_idx;
      end
      out_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("B_beat_count", 32'(nxt - 1), 32'd31);
      chk("B_done_count", 32'(dn), 32'd1);

      // restore with bubbles
      @(negedge clk);
      restore_req = 1'b1; in_valid = 1'b0;
      n = 1;
      for (int c = 0; c < 400 && n < 32; c++) begin
         @(negedge clk);
         restore_req = 1'b0;
         ir = in_ready;
         iv = ($urandom_range(0, 2) != 0);
         in_valid = iv; in_data = 32'h1000 + 32'(n);
         #1;
         chk("C_rf_we", {31'd0, rf_we}, {31'd0, iv && ir});
         if (iv && ir) begin
            chk("C_rf_a3", {27'd0, rf_a3}, 32'(n));
            chk("C_rf_wd", rf_wd, 32'h1000 + 32'(n));
            n++;
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      chk("C_done", {31'd0, done}, 32'd1);
      chk("C_busy", {31'd0, busy}, 32'd0);
      for (int i = 1; i < 32; i++) chk("C_rf_contents", rf0[i], 32'h1000 + 32'(i));
      chk("C_no_x0_write", 32'(x0_wr0), 32'd0);

      // abort after beat 10 of a save, then a fresh save restarts at x1
      @(negedge clk);
      save_req = 1'b1; out_ready = 1'b1;
      beats = 0;
      for (int c = 0; c < 100 && beats < 10; c++) begin
         @(negedge clk);
         save_req = 1'b0;
         if (out_valid) beats++;
      end
      @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("D_out_valid", {31'd0, out_valid}, 32'd0);
      chk("D_busy", {31'd0, busy}, 32'd0);
      dn = 0;
      repeat (4) begin
         if (done) dn++;
         @(negedge clk);
      end
      chk("D_no_done", 32'(dn), 32'd0);
      save_req = 1'b1;
      @(negedge clk);
      save_req = 1'b0;
      @(negedge clk);
      chk("D_restart_valid", {31'd0, out_valid}, 32'd1);
      chk("D_restart_idx", {27'd0, out_idx}, 32'd1);
      chk("D_restart_data", out_data, 32'h1001);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0; out_ready = 1'b0;

      // SKIP_X0=0: reset after 5 writes, then a full 32-beat restore
      @(negedge clk);
      restore_req1 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         restore_req1 = 1'b0;
         in_valid1 = 1'b1; in_data1 = 32'h2000 + 32'(k);
         #1;
         chk("E_we", {31'd0, rf_we1}, 32'd1);
         chk("E_a3", {27'd0, rf_a3_1}, 32'(k));
      end
      @(negedge clk);
      in_valid1 = 1'b0; reset1 = 1'b1;
      @(negedge clk);
      reset1 = 1'b0;
      chk("E_rst_busy", {31'd0, busy1}, 32'd0);
      chk("E_rst_done", {31'd0, done1}, 32'd0);
      chk("E_rst_in_ready", {31'd0, in_ready1}, 32'd0);
      chk("E_rst_out_valid", {31'd0, out_valid1}, 32'd0);
      chk("E_rst_out_last", {31'd0, out_last1}, 32'd0);
      chk("E_rst_out_data", out_data1, 32'd0);
      chk("E_rst_out_idx", {27'd0, out_idx1}, 32'd0);
      chk("E_rst_rf_we", {31'd0, rf_we1}, 32'd0);
      chk("E_rst_rf_a1", {27'd0, rf_a1_1}, 32'd0);
      chk("E_rst_rf_a3", {27'd0, rf_a3_1}, 32'd0);
      chk("E_rst_rf_wd", rf_wd1, 32'd0);
      chk("E_x0_write_issued", 32'(x0_wr1), 32'd1);
      for (int i = 1; i < 5; i++) chk("E_partial_rf", rf1[i], 32'h2000 + 32'(i));
      chk("E_x5_untouched", rf1[5], 32'd0);
      restore_req1 = 1'b1;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         restore_req1 = 1'b0;
         in_valid1 = 1'b1; in_data1 = 32'h3000 + 32'(k);
         #1;
         chk("E_full_we", {31'd0, rf_we1}, 32'd1);
         chk("E_full_a3", {27'd0, rf_a3_1}, 32'(k));
      end
      @(negedge clk);
      in_valid1 = 1'b0;
      chk("E_full_done", {31'd0, done1}, 32'd1);
      chk("E_full_busy", {31'd0, busy1}, 32'd0);
      chk("E_full_x31", rf1[31], 32'h301F);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_ctx_engine.md
# regfile_ctx_engine

Sequential context save/restore initiator for the 32×32 core register file. It drives the register file's read port A1/rd1 to stream every architectural register out over a valid/ready interface (save). It drives the write port A3/wd/we to refill the registers from an incoming valid/ready stream (restore). It sits beside the core datapath and owns the register file ports while `busy` is high; the core is stalled for that duration.

## Interface
Parameters:
- `SKIP_X0`, default 1: 1 = transfer x1..x31 (31 words); 0 = transfer x0..x31 (32 words).

Ports:
- `clk`  in  1  single clock; all state changes on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `save_req`  in  1  start save; sampled only in IDLE.
- `restore_req`  in  1  start restore; sampled only in IDLE.
- `abort`  in  1  cancel any operation.
- `busy`  out  1  high in SAVE or RESTORE.
- `done`  out  1  one-cycle pulse on normal completion.
- `rf_a1`  out  5  register file read address.
- `rf_rd1`  in  32  register file read data, combinational from `rf_a1`.
- `rf_we`  out  1  register file write enable.
- `rf_a3`  out  5  register file write address.
- `rf_wd`  out  32  register file write data.
- `out_valid`  out  1  save stream: data valid.
- `out_ready`  in  1  save stream: sink ready.
- `out_data`  out  32  saved register value, registered.
- `out_idx`  out  5  register index of `out_data`.
- `out_last`  out  1  high with the final word.
- `in_valid`  in  1  restore stream: data valid.
- `in_ready`  out  1  restore stream: engine ready.
- `in_data`  in  32  value to restore.

## Operation
- The FSM has three states:
  - IDLE: default state.
  - SAVE: entered from IDLE when `save_req` is high.
  - RESTORE: entered from IDLE when `restore_req` is high and `save_req` is low. If both requests are high, save wins.
- Requests outside IDLE are ignored.
- `FIRST` = `SKIP_X0 ? 1 : 0`. A 6-bit index counter is loaded with `FIRST` on entry to either SAVE or RESTORE.
- SAVE behaviour:
  - `rf_a1` = `idx[4:0]`.
  - Load condition: `!out_valid || out_ready`, with `idx <= 31`.
  - On load: `out_data <= rf_rd1`, `out_idx <= idx`, `out_last <= (idx == 31)`, `out_valid <= 1`, `idx <= idx + 1`.
  - On a handshake (`out_valid && out_ready`) with no new load: `out_valid <= 0`.
  - `out_data`, `out_idx` and `out_last` stay stable while `out_valid && !out_ready`.
  - On a handshake with `out_last` high: go to IDLE and pulse `done`.
- RESTORE behaviour:
  - `in_ready` = 1 while in RESTORE.
  - `rf_we` = `in_valid && in_ready`, combinational.
  - `rf_a3` = `idx[4:0]`; `rf_wd` = `in_data`.
  - On each accepted beat, `idx` increments.
  - On the beat accepted with `idx == 31`: go to IDLE and pulse `done`.
  - With `SKIP_X0 = 0`, the x0 write is issued anyway; the register file discards it.
- `abort` is high-priority. It forces IDLE on the next edge, clears `out_valid`, gives no `done`, and leaves registers already written as they are.
- In IDLE:
  - `rf_we`, `in_ready` and `out_valid` are 0.
  - `rf_a1`, `rf_a3` and `rf_wd` hold 0.
- The core must not write the register file while `busy` is high. The engine does not check this.

## Timing
- Reset values:
  - State IDLE; `idx` = 0.
  - `busy`, `done`, `out_valid`, `out_last`, `rf_we`, `in_ready` = 0.
  - `out_data` = 0; `out_idx` = 0.
  - `rf_a1`, `rf_a3`, `rf_wd` = 0.
- A reset mid-operation behaves the same as `abort`.
- Save timing, with `save_req` high in cycle 0:
  - `busy` is high from cycle 1.
  - The first `out_valid` appears in cycle 2.
  - With `out_ready` held high, there is one word per cycle. For `SKIP_X0 = 1`, this is cycles 2..32.
  - `done` pulses in cycle 33, and `busy` is low from cycle 33.
- Restore timing, with `restore_req` high in cycle 0:
  - `in_ready` is high from cycle 1.
  - With `in_valid` held high, writes occur in cycles 1..31.
  - `done` pulses in cycle 32, and `busy` is low from cycle 32.
- Backpressure and bubbles add cycles one-for-one. No word is skipped or duplicated.
- `done` and `busy` are never high in the same cycle.
- A new request is accepted in the `done` cycle.

## Test plan
- **Save with no backpressure.** Preload xN = 0xA5A50000+N, pulse `save_req`, hold `out_ready` = 1. Expect 31 beats in cycles 2..32 with `out_idx` 1..31 and matching data. `out_last` is high only at idx 31. `done` pulses in cycle 33.
- **Save with random backpressure.** Drive `out_ready` toggling pseudo-randomly. Expect data and idx to stay stable while stalled, 31 beats in order with none lost or repeated, and `done` once.
- **Restore with bubbles.** Drive 31 words 0x1000+N with `in_valid` gaps. Expect `rf_we` only on handshakes, x1..x31 equal to 0x1000+N, and x0 still reading 0. `done` pulses in the cycle after the last beat.
- **Simultaneous requests.** Pulse `save_req` and `restore_req` together. Expect SAVE to be entered. A `restore_req` during SAVE is ignored and `in_ready` stays 0.
- **Abort mid-save.** Assert `abort` after beat 10. Expect `out_valid` = 0 and `busy` = 0 next cycle, and no `done`. A later save restarts at idx 1.
- **Reset mid-restore with `SKIP_X0 = 0`.** Reset after 5 writes. Expect all outputs at reset values and x0..x4 written. A following restore of 32 beats starts at `rf_a3` = 0 and ends with `done`.
